// File: rtl/serial_twos_comp_mc.sv
// Multi-channel bit-serial two's complement negator.
// LSB-first words, per-channel negate mode, abort on restart.
module serial_twos_comp_mc #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic          t_clk,
  input  logic          r_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [CH-1:0] i,
  input  logic [CH-1:0] neg_en,
  output logic [CH-1:0] y,
  output logic          out_valid,
  output logic          out_last,
  output logic [CH-1:0] ovf,
  output logic          busy,
  output logic          abort
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_e;

  st_e st_q, st_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx;
  logic [CH-1:0] mode_q, mode_d;
  logic [CH-1:0] seen_q, seen_d;
  logic [CH-1:0] seen_b, mode_e;
  logic [CH-1:0] y_q, y_d;
  logic [CH-1:0] ovf_q, ovf_d;
  logic          ov_q, ov_d;
  logic          ol_q, ol_d;
  logic          ab_q, ab_d;
  logic          run;
  logic          restart;
  logic          take;
  logic          is_last;

  assign run     = (st_q == RUN);
  assign restart = in_valid & start;
  assign take    = in_valid & (start | run);

  // A restart overrides the word in flight: bit 0, fresh mode.
  assign idx     = restart ? '0 : cnt_q;
  assign seen_b  = restart ? '0 : seen_q;
  assign mode_e  = restart ? neg_en : mode_q;
  assign is_last = take & (idx == LAST);

  // State register
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state: enter on start, leave after the MSB
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (restart) st_d = RUN;
      RUN:  if (is_last) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = run;
  end

  // Datapath next-state: count, seen_one, serial result
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    seen_d = seen_q;
    y_d    = y_q;
    ovf_d  = '0;
    ov_d   = take;
    ol_d   = is_last;
    ab_d   = restart & run;
    if (take) begin
      mode_d = mode_e;
      seen_d = seen_b | i;
      y_d    = i ^ (mode_e & seen_b);
      cnt_d  = is_last ? '0 : idx + CW'(1);
    end
    if (is_last) begin
      ovf_d = mode_e & ~seen_b & i;
    end
  end

  // Datapath registers
  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      cnt_q  <= '0;
      mode_q <= '0;
      seen_q <= '0;
      y_q    <= '0;
      ovf_q  <= '0;
      ov_q   <= 1'b0;
      ol_q   <= 1'b0;
      ab_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      seen_q <= seen_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
      ov_q   <= ov_d;
      ol_q   <= ol_d;
      ab_q   <= ab_d;
    end
  end

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign abort     = ab_q;

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Bench for serial_twos_comp_mc: word-level arithmetic model,
// per-cycle compare, directed words plus random traffic.
module tb_serial_twos_comp_mc;

  localparam int W = 8;
  localparam int N = 4;

  typedef logic [N-1:0][W-1:0] words_t;

  logic         t_clk;
  logic         r_n;
  logic         start;
  logic         in_valid;
  logic [N-1:0] i;
  logic [N-1:0] neg_en;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_last;
  logic [N-1:0] ovf;
  logic         busy;
  logic         abort;

  serial_twos_comp_mc #(.WIDTH(W), .CH(N)) dut (
    .t_clk    (t_clk),
    .r_n      (r_n),
    .start    (start),
    .in_valid (in_valid),
    .i        (i),
    .neg_en   (neg_en),
    .y        (y),
    .out_valid(out_valid),
    .out_last (out_last),
    .ovf      (ovf),
    .busy     (busy),
    .abort    (abort)
  );

  initial begin
    t_clk = 1'b0;
    forever #5 t_clk = ~t_clk;
  end

  int checks;
  int failures;
  bit chk_on;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: keeps the received prefix of each word as a number and
  // derives every output bit from its arithmetic negation.
  logic [63:0]  m_pre [N];
  int           m_idx;
  bit           m_busy;
  logic [N-1:0] m_neg;
  logic [N-1:0] e_y;
  logic [N-1:0] e_ovf;
  bit           e_ov;
  bit           e_ol;
  bit           e_ab;

  task automatic model_reset();
    m_busy = 0;
    m_idx  = 0;
    m_neg  = '0;
    for (int c = 0; c < N; c++) m_pre[c] = '0;
    e_y   = '0;
    e_ovf = '0;
    e_ov  = 0;
    e_ol  = 0;
    e_ab  = 0;
  endtask

  task automatic model_step(input bit st, input bit iv,
                            input logic [N-1:0] bi,
                            input logic [N-1:0] ng);
    logic [63:0] nv;
    e_ov  = 0;
    e_ol  = 0;
    e_ab  = 0;
    e_ovf = '0;
    if (iv && (st || m_busy)) begin
      if (st) begin
        e_ab   = m_busy;
        m_busy = 1;
        m_idx  = 0;
        m_neg  = ng;
        for (int c = 0; c < N; c++) m_pre[c] = '0;
      end
      for (int c = 0; c < N; c++) begin
        m_pre[c][m_idx] = bi[c];
        nv = ~m_pre[c] + 64'd1;
        e_y[c] = m_neg[c] ? nv[m_idx] : bi[c];
      end
      e_ov = 1;
      if (m_idx == W - 1) begin
        e_ol = 1;
        for (int c = 0; c < N; c++)
          e_ovf[c] = m_neg[c] && (m_pre[c] == (64'd1 << (W - 1)));
        m_busy = 0;
      end
      m_idx++;
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge t_clk) begin
    if (chk_on) begin
      chk("y", 64'(y), 64'(e_y));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("out_last", 64'(out_last), 64'(e_ol));
      chk("ovf", 64'(ovf), 64'(e_ovf));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("abort", 64'(abort), 64'(e_ab));
    end
  end

  task automatic cyc(input bit st, input bit iv,
                     input logic [N-1:0] bi,
                     input logic [N-1:0] ng);
    start    = st;
    in_valid = iv;
    i        = bi;
    neg_en   = ng;
    @(posedge t_clk);
    #1;
    model_step(st, iv, bi, ng);
    @(negedge t_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, '0);
  endtask

  task automatic reset_pulse();
    #2;
    r_n      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_flags", 64'({out_valid, out_last, busy, abort}), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge t_clk);
    r_n = 1'b1;
  endtask

  // Sends nb bits of a word (start on bit 0), optional stall after bit k.
  // neg_en is scrambled on non-start cycles; it must be ignored there.
  task automatic send_word(input words_t w, input logic [N-1:0] ng,
                           input logic [W-1:0] stall, input int nb,
                           output words_t got, output logic [N-1:0] gov,
                           output int nv, output int nl, output bit ab);
    logic [N-1:0] bi;
    got = '0;
    gov = '0;
    nv  = 0;
    nl  = 0;
    ab  = 0;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < N; c++) bi[c] = w[c][k];
      cyc(k == 0, 1, bi, (k == 0) ? ng : ~ng);
      if (out_valid) nv++;
      for (int c = 0; c < N; c++) got[c][k] = y[c];
      if (out_last) begin
        nl++;
        gov = ovf;
      end
      if (abort) ab = 1;
      if (stall[k]) cyc(0, 0, $urandom_range(0, 15), '1);
    end
  endtask

  words_t       w, got;
  logic [N-1:0] gov;
  int           nv, nl, nv2, nl2;
  bit           ab;

  initial begin
    checks   = 0;
    failures = 0;
    chk_on   = 0;
    r_n      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    i        = '0;
    neg_en   = '0;
    model_reset();
    repeat (2) @(negedge t_clk);
    chk("reset_y", 64'(y), 64'd0);
    chk("reset_flags", 64'({out_valid, out_last, busy, abort}), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    r_n    = 1'b1;
    chk_on = 1;
    idle(2);

    // Idle traffic without start is ignored
    for (int k = 0; k < 3; k++) cyc(0, 1, $urandom_range(0, 15), '1);

    // Basic word, no stalls
    w = {8'h00, 8'h80, 8'h5A, 8'h0C};
    send_word(w, 4'b1101, '0, W, got, gov, nv, nl, ab);
    chk("w1_ch0", 64'(got[0]), 64'hF4);
    chk("w1_ch1", 64'(got[1]), 64'h5A);
    chk("w1_ch2", 64'(got[2]), 64'h80);
    chk("w1_ch3", 64'(got[3]), 64'h00);
    chk("w1_ovf", 64'(gov), 64'b0100);
    chk("w1_nvalid", 64'(nv), 64'd8);
    chk("w1_nlast", 64'(nl), 64'd1);
    idle(2);

    // Same word with stalls after bits 2 and 5
    send_word(w, 4'b1101, 8'b0010_0100, W, got, gov, nv, nl, ab);
    chk("w2_ch0", 64'(got[0]), 64'hF4);
    chk("w2_ch1", 64'(got[1]), 64'h5A);
    chk("w2_ch2", 64'(got[2]), 64'h80);
    chk("w2_ovf", 64'(gov), 64'b0100);
    idle(2);

    // Back-to-back words, no bubble
    w = {4{8'h01}};
    send_word(w, 4'hF, '0, W, got, gov, nv, nl, ab);
    chk("b2b_a", 64'(got[1]), 64'hFF);
    w = {4{8'hFF}};
    send_word(w, 4'hF, '0, W, got, gov, nv2, nl2, ab);
    chk("b2b_b", 64'(got[2]), 64'h01);
    chk("b2b_nvalid", 64'(nv + nv2), 64'd16);
    idle(2);

    // Restart in the middle of a word
    w = {4{8'h0C}};
    send_word(w, 4'hF, '0, 4, got, gov, nv, nl, ab);
    chk("abrt_nolast", 64'(nl), 64'd0);
    w = {4{8'h03}};
    send_word(w, 4'hF, '0, W, got, gov, nv, nl, ab);
    chk("abrt_pulse", 64'(ab), 64'd1);
    chk("abrt_word", 64'(got[0]), 64'hFD);
    chk("abrt_nvalid", 64'(nv), 64'd8);
    idle(2);

    // Reset in the middle of a word
    w = {4{8'hA5}};
    send_word(w, 4'hA, '0, 3, got, gov, nv, nl, ab);
    reset_pulse();
    nv = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, $urandom_range(0, 15), '1);
      if (out_valid) nv++;
    end
    chk("post_rst_nostart", 64'(nv), 64'd0);
    w = {4{8'h7F}};
    send_word(w, 4'hF, '0, W, got, gov, nv, nl, ab);
    chk("post_rst_word", 64'(got[3]), 64'h81);
    chk("post_rst_ovf", 64'(gov), 64'd0);
    idle(2);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      bit st;
      if ($urandom_range(0, 299) == 0) reset_pulse();
      st = m_busy ? ($urandom_range(0, 15) == 0)
                  : ($urandom_range(0, 2) == 0);
      cyc(st, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15), $urandom_range(0, 15));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
